// File: rtl/psg_array_mixer.sv
// psg_array_mixer: chip-select decode, BC routing / read-data mux, per-chip
// activity hold-off and a sequential A/B/C mixing pass for NUM_CHIPS external
// AY/YM PSG instances.
module psg_array_mixer #(
    parameter int NUM_CHIPS   = 2,
    parameter int W           = 8,
    parameter int DEFAULT_SEL = 1,
    parameter int HOLD_CYCLES = 4096,
    localparam int SELW       = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1,
    localparam int AW         = W + SELW
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   CE,
    input  logic                   BDIR,
    input  logic                   BC,
    input  logic [7:0]             DI,
    output logic [7:0]             DO,
    output logic [NUM_CHIPS-1:0]   BC_OUT,
    input  logic [8*NUM_CHIPS-1:0] CHIP_DO,
    input  logic [W*NUM_CHIPS-1:0] CHIP_A,
    input  logic [W*NUM_CHIPS-1:0] CHIP_B,
    input  logic [W*NUM_CHIPS-1:0] CHIP_C,
    input  logic [NUM_CHIPS-1:0]   CHIP_ACTIVE,
    input  logic [1:0]             MIX_MODE,
    output logic [W-1:0]           CHANNEL_A,
    output logic [W-1:0]           CHANNEL_B,
    output logic [W-1:0]           CHANNEL_C,
    output logic                   OUT_VALID,
    output logic [SELW-1:0]        SEL_IDX,
    output logic [NUM_CHIPS-1:0]   PLAYING,
    output logic                   ACTIVE
);

    localparam int CNTW = $clog2(HOLD_CYCLES + 1);
    localparam int NW   = $clog2(NUM_CHIPS + 1);

    localparam logic [CNTW-1:0] HOLD_LOAD   = CNTW'(HOLD_CYCLES);
    localparam logic [SELW-1:0] SEL_RST     = SELW'(DEFAULT_SEL);
    localparam logic [SELW-1:0] LAST_K      = SELW'(NUM_CHIPS - 1);
    localparam logic [SELW:0]   NUM_CHIPS_W = (SELW + 1)'(NUM_CHIPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_NORM = 2'd2
    } state_t;

    // Saturate an accumulator into the W-bit channel range.
    function automatic logic [W-1:0] f_sat(input logic [AW-1:0] acc);
        logic [W-1:0] res;
        if (|acc[AW-1:W]) res = '1;
        else              res = acc[W-1:0];
        return res;
    endfunction

    // Final per-channel result from the accumulated pass.
    function automatic logic [W-1:0] f_mix(
        input logic [AW-1:0] acc,
        input logic [NW-1:0] n,
        input logic [1:0]    mode,
        input logic [W-1:0]  raw_def,
        input logic [W-1:0]  raw_last
    );
        logic [W-1:0] res;
        // Average over the chip slots; acc is W+SELW wide so this always fits W.
        res = acc[AW-1:SELW];
        if (n == '0) begin
            res = raw_def;
        end else begin
            case (mode)
                2'd0:    if (n == NW'(1)) res = raw_last;
                2'd2:    res = f_sat(acc);
                default: res = acc[AW-1:SELW];
            endcase
        end
        return res;
    endfunction

    state_t          r_state;
    logic [SELW-1:0] r_sel;
    logic [SELW-1:0] r_k;
    logic [SELW-1:0] r_last;
    logic [NW-1:0]   r_n;
    logic [AW-1:0]   r_acc_a, r_acc_b, r_acc_c;
    logic            r_pend;
    logic [W-1:0]    r_cha, r_chb, r_chc;
    logic            r_vld;
    logic [CNTW-1:0] r_cnt [NUM_CHIPS];
    logic [NUM_CHIPS-1:0] r_play;

    logic                 w_esc;
    logic [SELW-1:0]      w_esc_idx;
    logic                 w_esc_ok;
    logic [NUM_CHIPS-1:0] w_bc_out;
    logic [7:0]           w_do;
    logic [W-1:0]         w_a_k, w_b_k, w_c_k;
    logic [W-1:0]         w_a_last, w_b_last, w_c_last;
    logic [W-1:0]         w_a_def, w_b_def, w_c_def;
    logic                 w_play_k;

    // Escape write: upper DI bits all ones, low bits carry the chip index.
    assign w_esc_idx = DI[SELW-1:0];
    assign w_esc     = BDIR & BC & (&DI[7:SELW]);
    assign w_esc_ok  = ({1'b0, w_esc_idx} < NUM_CHIPS_W);

    assign w_a_def = CHIP_A[DEFAULT_SEL*W +: W];
    assign w_b_def = CHIP_B[DEFAULT_SEL*W +: W];
    assign w_c_def = CHIP_C[DEFAULT_SEL*W +: W];

    // Chip-indexed muxes: bus routing by SEL_IDX, pass sampling by r_k / r_last.
    always_comb begin
        w_bc_out = '0;
        w_do     = '0;
        w_a_k    = '0;
        w_b_k    = '0;
        w_c_k    = '0;
        w_play_k = 1'b0;
        w_a_last = '0;
        w_b_last = '0;
        w_c_last = '0;
        for (int k = 0; k < NUM_CHIPS; k++) begin
            w_bc_out[k] = BC & (r_sel == SELW'(k));
            if (r_sel == SELW'(k)) w_do = CHIP_DO[k*8 +: 8];
            if (r_k == SELW'(k)) begin
                w_a_k    = CHIP_A[k*W +: W];
                w_b_k    = CHIP_B[k*W +: W];
                w_c_k    = CHIP_C[k*W +: W];
                w_play_k = r_play[k];
            end
            if (r_last == SELW'(k)) begin
                w_a_last = CHIP_A[k*W +: W];
                w_b_last = CHIP_B[k*W +: W];
                w_c_last = CHIP_C[k*W +: W];
            end
        end
    end

    // Chip select register, updated by a valid escape write.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                r_sel <= SEL_RST;
        else if (w_esc && w_esc_ok)  r_sel <= w_esc_idx;
    end

    // Per-chip hold-off counters, reloaded while active and drained on CE.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < NUM_CHIPS; k++) r_cnt[k] <= '0;
        end else if (CE) begin
            for (int k = 0; k < NUM_CHIPS; k++) begin
                if (CHIP_ACTIVE[k])      r_cnt[k] <= HOLD_LOAD;
                else if (r_cnt[k] != '0) r_cnt[k] <= r_cnt[k] - CNTW'(1);
            end
        end
    end

    // Registered per-chip playing flags.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_play <= '0;
        end else begin
            for (int k = 0; k < NUM_CHIPS; k++)
                r_play[k] <= CHIP_ACTIVE[k] | (r_cnt[k] != '0);
        end
    end

    // Mix pass FSM: accumulate one chip per clock, then normalise and publish.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_last  <= '0;
            r_n     <= '0;
            r_acc_a <= '0;
            r_acc_b <= '0;
            r_acc_c <= '0;
            r_pend  <= 1'b0;
            r_cha   <= '0;
            r_chb   <= '0;
            r_chc   <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (CE || r_pend) begin
                        r_state <= S_ACC;
                        r_k     <= '0;
                        r_n     <= '0;
                        r_acc_a <= '0;
                        r_acc_b <= '0;
                        r_acc_c <= '0;
                        r_pend  <= 1'b0;
                    end
                end
                S_ACC: begin
                    if (CE) r_pend <= 1'b1;
                    if (w_play_k) begin
                        r_acc_a <= r_acc_a + {{SELW{1'b0}}, w_a_k};
                        r_acc_b <= r_acc_b + {{SELW{1'b0}}, w_b_k};
                        r_acc_c <= r_acc_c + {{SELW{1'b0}}, w_c_k};
                        r_n     <= r_n + NW'(1);
                        r_last  <= r_k;
                    end
                    if (r_k == LAST_K) r_state <= S_NORM;
                    else               r_k     <= r_k + SELW'(1);
                end
                S_NORM: begin
                    if (CE) r_pend <= 1'b1;
                    r_cha   <= f_mix(r_acc_a, r_n, MIX_MODE, w_a_def, w_a_last);
                    r_chb   <= f_mix(r_acc_b, r_n, MIX_MODE, w_b_def, w_b_last);
                    r_chc   <= f_mix(r_acc_c, r_n, MIX_MODE, w_c_def, w_c_last);
                    r_vld   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign DO        = w_do;
    assign BC_OUT    = w_bc_out;
    assign SEL_IDX   = r_sel;
    assign PLAYING   = r_play;
    assign ACTIVE    = |r_play;
    assign CHANNEL_A = r_cha;
    assign CHANNEL_B = r_chb;
    assign CHANNEL_C = r_chc;
    assign OUT_VALID = r_vld;

endmodule
